pc_sequencer: RTL and testbench
===============================

PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset; SHALL be word aligned.
REQ-002 clk_i  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 rst_i  input  1  reset, asynchronous and active-high.
REQ-004 stall_i  input  1  hazard hold; while high the PC SHALL NOT advance.
REQ-005 imem_ready_i  input  1  instruction memory accepted the current fetch this cycle.
REQ-006 jump_i  input  1  current instruction is j/jal.
REQ-007 jr_i  input  1  current instruction is jr.
REQ-008 branch_i  input  1  current instruction is a taken branch.
REQ-009 jtarget_i  input  26  instr[25:0] jump index.
REQ-010 imm_ext_i  input  32  sign-extended branch offset, in words.
REQ-011 rs_data_i  input  32  jr target register value.
REQ-012 pc_o  output  32  current fetch address.
REQ-013 fetch_req_o  output  1  fetch request to instruction memory.
REQ-014 redirect_o  output  1  one-cycle pulse when a non-sequential PC is loaded.
REQ-015 misalign_o  output  1  sticky flag: a jr target had rs_data_i[1:0] != 0.
REQ-016 redirect_cnt_o  output  8  count of non-sequential PC loads, saturating.

Function
REQ-017 The block SHALL compute pc_plus4 = pc_o + 4 (mod 2^32).
REQ-018 Jump target SHALL be {pc_plus4[31:28], jtarget_i, 2'b00}.
REQ-019 Branch target SHALL be pc_plus4 + {imm_ext_i[29:0], 2'b00} (mod 2^32).
REQ-020 jr target SHALL be {rs_data_i[31:2], 2'b00}.
REQ-021 Priority when several controls are high SHALL be jr_i > jump_i > branch_i > sequential.
REQ-022 FSM states BOOT, RUN, HOLD; reset state BOOT.
REQ-023 BOOT: fetch_req_o=0; SHALL go to RUN on the next edge unconditionally.
REQ-024 RUN: fetch_req_o=1; advance condition = imem_ready_i & ~stall_i.
REQ-025 RUN, advance true: pc_o SHALL load the selected next PC on that edge (latency 1 cycle); stay RUN.
REQ-026 RUN, imem_ready_i=0 with any control input high: SHALL latch the selected target into a pending register, set pending valid, go HOLD; pc_o unchanged.
REQ-027 RUN, stall_i=1 with imem_ready_i=1: pc_o unchanged, stay RUN, no capture (control inputs are held by the pipeline during stall).
REQ-028 HOLD: fetch_req_o=1; control inputs SHALL be ignored; on imem_ready_i & ~stall_i pc_o SHALL load the pending target, clear pending valid, go RUN.
REQ-029 redirect_o SHALL be 1 for exactly the cycle after each edge that loads a non-sequential PC (RUN or HOLD path), else 0.
REQ-030 redirect_cnt_o SHALL increment on each non-sequential load and saturate at 8'hFF.
REQ-031 misalign_o SHALL set on the edge a jr target with rs_data_i[1:0]!=0 is selected and loaded or captured; cleared only by reset.
REQ-032 Sequential wrap: pc_o=32'hFFFF_FFFC advancing SHALL yield 32'h0000_0000.

Reset
REQ-033 While rst_i=1, regardless of clock: pc_o=RESET_PC, state BOOT, fetch_req_o=0, redirect_o=0, misalign_o=0, redirect_cnt_o=0, pending valid=0.
REQ-034 Reset asserted in HOLD SHALL discard the pending target; first fetch after release SHALL be RESET_PC.

Verification
REQ-035 Reset release, imem_ready_i=1, no controls -> BOOT one cycle, then pc_o 0,4,8,C on successive edges, redirect_o=0.
REQ-036 pc_o=32'h0040_0010, jump_i=1, jtarget_i=26'h010_0008 -> next pc_o=32'h0040_0020, redirect_o pulse, redirect_cnt_o=1.
REQ-037 pc_o=32'h0000_0100, branch_i=1, imm_ext_i=32'hFFFF_FFFE -> next pc_o=32'h0000_00FC; branch_i with jr_i=1, rs_data_i=32'h0000_0203 -> pc_o=32'h0000_0200, misalign_o=1.
REQ-038 jump_i=1 with imem_ready_i=0 for 3 cycles, jump_i dropped after 1 -> state HOLD, pc_o unchanged; on imem_ready_i=1 pc_o=jump target.
REQ-039 stall_i=1 for 4 cycles at pc_o=32'h20 -> pc_o stays 32'h20, fetch_req_o=1; released -> 32'h24.
REQ-040 256+ redirects -> redirect_cnt_o holds 8'hFF; rst_i pulse mid-cycle in HOLD -> outputs immediately at reset values.

Source files
------------

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: sequential / jump / branch / jr next-PC selection with fetch handshake.
// Latency: one cycle from an accepted fetch (imem_ready_i & ~stall_i) to the new pc_o.
// Backpressure: stall_i or a missing imem_ready_i holds pc_o; a redirect seen without ready is parked until accepted.
module pc_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        stall_i,
    input  logic        imem_ready_i,
    input  logic        jump_i,
    input  logic        jr_i,
    input  logic        branch_i,
    input  logic [25:0] jtarget_i,
    input  logic [31:0] imm_ext_i,
    input  logic [31:0] rs_data_i,
    output logic [31:0] pc_o,
    output logic        fetch_req_o,
    output logic        redirect_o,
    output logic        misalign_o,
    output logic [7:0]  redirect_cnt_o
);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t      state;
    logic [31:0] pend_pc;
    logic        pend_vld;

    logic [31:0] pc_plus4;
    logic [31:0] br_off;
    logic [31:0] jump_tgt;
    logic [31:0] branch_tgt;
    logic [31:0] jr_tgt;
    logic [31:0] sel_tgt;
    logic        ctrl_any;
    logic        jr_misalign;
    logic        advance;
    logic [7:0]  cnt_next;

    always_comb begin
        pc_plus4   = pc_o + 32'd4;
        br_off     = imm_ext_i << 2;
        jump_tgt   = {pc_plus4[31:28], jtarget_i, 2'b00};
        branch_tgt = pc_plus4 + br_off;
        jr_tgt     = rs_data_i & 32'hFFFF_FFFC;
        ctrl_any   = jr_i | jump_i | branch_i;
        jr_misalign = jr_i & (rs_data_i[1:0] != 2'b00);
        advance    = imem_ready_i & ~stall_i;
        cnt_next   = (redirect_cnt_o == 8'hFF) ? 8'hFF : redirect_cnt_o + 8'd1;
    end

    // jr wins over jump, jump over branch; sequential only when no control is raised.
    always_comb begin
        sel_tgt = pc_plus4;
        if (jr_i) begin
            sel_tgt = jr_tgt;
        end else if (jump_i) begin
            sel_tgt = jump_tgt;
        end else if (branch_i) begin
            sel_tgt = branch_tgt;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state          <= BOOT;
            pc_o           <= RESET_PC;
            pend_pc        <= RESET_PC;
            pend_vld       <= 1'b0;
            fetch_req_o    <= 1'b0;
            redirect_o     <= 1'b0;
            misalign_o     <= 1'b0;
            redirect_cnt_o <= 8'd0;
        end else begin
            redirect_o <= 1'b0;
            case (state)
                BOOT: begin
                    state       <= RUN;
                    fetch_req_o <= 1'b1;
                end

                RUN: begin
                    fetch_req_o <= 1'b1;
                    if (advance) begin
                        pc_o <= sel_tgt;
                        if (ctrl_any) begin
                            redirect_o     <= 1'b1;
                            redirect_cnt_o <= cnt_next;
                        end
                        if (jr_misalign) begin
                            misalign_o <= 1'b1;
                        end
                    end else if (!imem_ready_i && ctrl_any) begin
                        // Memory did not take this fetch; park the redirect so the
                        // pipeline may drop its control lines while we wait.
                        pend_pc  <= sel_tgt;
                        pend_vld <= 1'b1;
                        state    <= HOLD;
                        if (jr_misalign) begin
                            misalign_o <= 1'b1;
                        end
                    end
                end

                HOLD: begin
                    fetch_req_o <= 1'b1;
                    if (advance && pend_vld) begin
                        pc_o           <= pend_pc;
                        pend_vld       <= 1'b0;
                        state          <= RUN;
                        redirect_o     <= 1'b1;
                        redirect_cnt_o <= cnt_next;
                    end
                end

                default: begin
                    state       <= BOOT;
                    fetch_req_o <= 1'b0;
                    pend_vld    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed vector table, hand-written reset/saturation/wrap sequences,
// then randomized traffic against a behavioural next-PC model.
module tb_pc_sequencer;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        ready;
    logic        jump;
    logic        jr;
    logic        branch;
    logic [25:0] jt;
    logic [31:0] imm;
    logic [31:0] rs;
    logic [31:0] pc;
    logic        fetch;
    logic        red;
    logic        mis;
    logic [7:0]  cnt;

    int errors = 0;
    int checks = 0;

    pc_sequencer #(.RESET_PC(32'h0000_0000)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .stall_i        (stall),
        .imem_ready_i   (ready),
        .jump_i         (jump),
        .jr_i           (jr),
        .branch_i       (branch),
        .jtarget_i      (jt),
        .imm_ext_i      (imm),
        .rs_data_i      (rs),
        .pc_o           (pc),
        .fetch_req_o    (fetch),
        .redirect_o     (red),
        .misalign_o     (mis),
        .redirect_cnt_o (cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        stall;
        logic        ready;
        logic        jump;
        logic        jr;
        logic        branch;
        logic [25:0] jt;
        logic [31:0] imm;
        logic [31:0] rs;
        logic [31:0] pc;
        logic        red;
        logic [7:0]  cnt;
        logic        mis;
    } vec_t;

    vec_t tbl[22];

    // Reference model state: whether we are still in the boot cycle, and an
    // optional parked redirect target.
    bit          m_boot;
    bit          m_parked;
    logic [31:0] m_park_pc;
    logic [31:0] m_pc;
    int          m_redirects;
    bit          m_red;
    bit          m_mis;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp_v, $time);
        end
    endtask

    task automatic idle_inputs();
        stall = 0; ready = 1; jump = 0; jr = 0; branch = 0;
        jt = '0; imm = '0; rs = '0;
    endtask

    task automatic set_in(input logic s, input logic r, input logic j, input logic rr,
                          input logic b, input logic [25:0] t, input logic [31:0] i,
                          input logic [31:0] d);
        stall = s; ready = r; jump = j; jr = rr; branch = b; jt = t; imm = i; rs = d;
    endtask

    task automatic model_reset();
        m_boot = 1; m_parked = 0; m_park_pc = '0; m_pc = 32'h0;
        m_redirects = 0; m_red = 0; m_mis = 0;
    endtask

    // Next PC chosen straight from the instruction-set rules.
    function automatic logic [31:0] model_target();
        logic [31:0] seq;
        seq = m_pc + 32'd4;
        if (jr)          return {rs[31:2], 2'b00};
        else if (jump)   return {seq[31:28], jt, 2'b00};
        else if (branch) return seq + (imm * 32'd4);
        else             return seq;
    endfunction

    task automatic model_step();
        bit taken;
        bit is_ctrl;
        taken   = ready && !stall;
        is_ctrl = jr || jump || branch;
        m_red   = 0;
        if (m_boot) begin
            m_boot = 0;
        end else if (m_parked) begin
            if (taken) begin
                m_pc = m_park_pc; m_parked = 0; m_red = 1; m_redirects++;
            end
        end else if (taken) begin
            if (jr && rs[1:0] != 0) m_mis = 1;
            m_pc = model_target();
            if (is_ctrl) begin m_red = 1; m_redirects++; end
        end else if (!ready && is_ctrl) begin
            if (jr && rs[1:0] != 0) m_mis = 1;
            m_park_pc = model_target(); m_parked = 1;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        rst = 0;
        model_reset();
    endtask

    initial begin
        logic [7:0] m_cnt8;

        tbl[0]  = '{0,1,0,0,0,26'h0,32'h0,32'h0,              32'h0000_0000,0,8'd0,0};
        tbl[1]  = '{0,1,0,0,0,26'h0,32'h0,32'h0,              32'h0000_0004,0,8'd0,0};
        tbl[2]  = '{0,1,0,0,0,26'h0,32'h0,32'h0,              32'h0000_0008,0,8'd0,0};
        tbl[3]  = '{0,1,0,0,0,26'h0,32'h0,32'h0,              32'h0000_000C,0,8'd0,0};
        tbl[4]  = '{0,1,0,1,0,26'h0,32'h0,32'h0040_0010,      32'h0040_0010,1,8'd1,0};
        tbl[5]  = '{0,1,1,0,0,26'h010_0008,32'h0,32'h0,       32'h0040_0020,1,8'd2,0};
        tbl[6]  = '{0,1,0,0,0,26'h0,32'h0,32'h0,              32'h0040_0024,0,8'd2,0};
        tbl[7]  = '{0,1,0,1,0,26'h0,32'h0,32'h0000_0100,      32'h0000_0100,1,8'd3,0};
        tbl[8]  = '{0,1,0,0,1,26'h0,32'hFFFF_FFFE,32'h0,      32'h0000_00FC,1,8'd4,0};
        tbl[9]  = '{0,1,0,1,1,26'h0,32'h0000_0040,32'h0000_0203,32'h0000_0200,1,8'd5,1};
        tbl[10] = '{0,1,0,1,0,26'h0,32'h0,32'h0000_0020,      32'h0000_0020,1,8'd6,1};
        tbl[11] = '{1,1,0,0,0,26'h0,32'h0,32'h0,              32'h0000_0020,0,8'd6,1};
        tbl[12] = '{1,1,0,0,0,26'h0,32'h0,32'h0,              32'h0000_0020,0,8'd6,1};
        tbl[13] = '{1,1,0,0,0,26'h0,32'h0,32'h0,              32'h0000_0020,0,8'd6,1};
        tbl[14] = '{1,1,0,0,0,26'h0,32'h0,32'h0,              32'h0000_0020,0,8'd6,1};
        tbl[15] = '{0,1,0,0,0,26'h0,32'h0,32'h0,              32'h0000_0024,0,8'd6,1};
        tbl[16] = '{0,0,1,0,0,26'h000_0040,32'h0,32'h0,       32'h0000_0024,0,8'd6,1};
        tbl[17] = '{0,0,0,0,1,26'h0,32'h0000_0010,32'h0,      32'h0000_0024,0,8'd6,1};
        tbl[18] = '{0,0,0,0,0,26'h0,32'h0,32'h0,              32'h0000_0024,0,8'd6,1};
        tbl[19] = '{1,1,0,1,0,26'h0,32'h0,32'h0000_0800,      32'h0000_0024,0,8'd6,1};
        tbl[20] = '{0,1,0,0,0,26'h0,32'h0,32'h0,              32'h0000_0100,1,8'd7,1};
        tbl[21] = '{0,1,0,0,0,26'h0,32'h0,32'h0,              32'h0000_0104,0,8'd7,1};

        rst = 1;
        idle_inputs();
        #2;
        check("reset_pc", pc, 32'h0);
        check("reset_fetch", {31'd0, fetch}, 32'd0);
        check("reset_redirect", {31'd0, red}, 32'd0);
        check("reset_cnt", {24'd0, cnt}, 32'd0);
        check("reset_misalign", {31'd0, mis}, 32'd0);
        do_reset();
        check("boot_fetch_low", {31'd0, fetch}, 32'd0);

        for (int i = 0; i < 22; i++) begin
            set_in(tbl[i].stall, tbl[i].ready, tbl[i].jump, tbl[i].jr, tbl[i].branch,
                   tbl[i].jt, tbl[i].imm, tbl[i].rs);
            tick();
            check($sformatf("vec%0d_pc", i), pc, tbl[i].pc);
            check($sformatf("vec%0d_redirect", i), {31'd0, red}, {31'd0, tbl[i].red});
            check($sformatf("vec%0d_cnt", i), {24'd0, cnt}, {24'd0, tbl[i].cnt});
            check($sformatf("vec%0d_misalign", i), {31'd0, mis}, {31'd0, tbl[i].mis});
            check($sformatf("vec%0d_fetch", i), {31'd0, fetch}, 32'd1);
        end

        // Reset arriving mid-cycle while a redirect is parked.
        set_in(0, 0, 1, 0, 0, 26'h000_0100, 32'h0, 32'h0);
        tick();
        idle_inputs();
        ready = 0;
        #3;
        rst = 1;
        #1;
        check("hold_rst_pc", pc, 32'h0);
        check("hold_rst_fetch", {31'd0, fetch}, 32'd0);
        check("hold_rst_cnt", {24'd0, cnt}, 32'd0);
        check("hold_rst_misalign", {31'd0, mis}, 32'd0);
        check("hold_rst_redirect", {31'd0, red}, 32'd0);
        tick();
        rst = 0;
        ready = 1;
        tick();
        check("post_rst_boot_pc", pc, 32'h0);
        check("post_rst_fetch", {31'd0, fetch}, 32'd1);
        tick();
        check("post_rst_seq_pc", pc, 32'h4);
        check("post_rst_no_redirect", {31'd0, red}, 32'd0);

        // Redirect counter saturation.
        for (int i = 1; i <= 300; i++) begin
            set_in(0, 1, 0, 1, 0, 26'h0, 32'h0, 32'(i) << 4);
            tick();
            if (i == 254 || i == 255 || i == 256 || i == 300)
                check($sformatf("sat_cnt_%0d", i), {24'd0, cnt}, (i >= 255) ? 32'hFF : 32'(i));
        end
        check("sat_redirect", {31'd0, red}, 32'd1);

        // Sequential wrap at the top of the address space.
        set_in(0, 1, 0, 1, 0, 26'h0, 32'h0, 32'hFFFF_FFFC);
        tick();
        check("wrap_pre_pc", pc, 32'hFFFF_FFFC);
        idle_inputs();
        tick();
        check("wrap_pc", pc, 32'h0);
        check("wrap_cnt_held", {24'd0, cnt}, 32'hFF);

        // Randomized traffic against the model.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 299) == 0) begin
                do_reset();
            end else begin
                stall  = ($urandom_range(0, 4) == 0);
                ready  = ($urandom_range(0, 3) != 0);
                jump   = ($urandom_range(0, 5) == 0);
                jr     = ($urandom_range(0, 7) == 0);
                branch = ($urandom_range(0, 4) == 0);
                jt     = 26'($urandom);
                imm    = ($urandom_range(0, 1) == 0) ? 32'($signed(16'($urandom))) : $urandom;
                rs     = ($urandom_range(0, 3) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
                tick();
                model_step();
            end
            m_cnt8 = (m_redirects > 255) ? 8'hFF : 8'(m_redirects);
            check("rnd_pc", pc, m_pc);
            check("rnd_redirect", {31'd0, red}, {31'd0, m_red});
            check("rnd_cnt", {24'd0, cnt}, {24'd0, m_cnt8});
            check("rnd_misalign", {31'd0, mis}, {31'd0, m_mis});
            check("rnd_fetch", {31'd0, fetch}, {31'd0, !m_boot});
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
